// File: rtl/config_chain_loader.sv
// Purpose : streams CHAIN_LEN config bits, LSB first, from WORD_W-bit words into a serial chain, then pulses chain_set and done.
// Latency : start->LOAD 1 cycle; word accept->first bit 1 cycle; last bit->chain_set 1 cycle, ->done 2 cycles.
// Backpress: cfg_ready is high only in LOAD; with cfg_valid low the loader stalls in LOAD with chain_cen=0.
//
// Ports:
//   clk, rst            - clock, asynchronous active-low reset
//   start, abort        - begin a full load (IDLE only) / cancel an in-progress load
//   cfg_valid/cfg_ready - word handshake, cfg_data bit 0 shifts first
//   chain_cen/chain_shift/chain_set - shift enable, serial data, latch pulse to the chain
//   busy, done          - high outside IDLE / one-cycle completion pulse
module config_chain_loader #(
    parameter int CHAIN_LEN = 128,
    parameter int WORD_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [WORD_W-1:0] cfg_data,
    output logic              chain_cen,
    output logic              chain_shift,
    output logic              chain_set,
    output logic              busy,
    output logic              done
);

    localparam int RW = $clog2(CHAIN_LEN + 1);
    localparam int WW = $clog2(WORD_W + 1);

    localparam logic [RW-1:0] REM_FULL  = RW'(CHAIN_LEN);
    localparam logic [RW-1:0] REM_ONE   = RW'(1);
    localparam logic [WW-1:0] WCNT_ONE  = WW'(1);
    localparam logic [WW-1:0] WCNT_FULL = WW'(WORD_W);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        SET,
        DONE
    } state_t;

    state_t            state, state_nxt;
    logic [RW-1:0]     remaining, remaining_nxt;
    logic [WW-1:0]     wcnt, wcnt_nxt;
    logic [WORD_W-1:0] sreg, sreg_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            remaining <= '0;
            wcnt      <= '0;
            sreg      <= '0;
        end else begin
            state     <= state_nxt;
            remaining <= remaining_nxt;
            wcnt      <= wcnt_nxt;
            sreg      <= sreg_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        wcnt_nxt      = wcnt;
        sreg_nxt      = sreg;

        case (state)
            IDLE: begin
                // start together with abort is treated as no request.
                if (start && !abort) begin
                    state_nxt     = LOAD;
                    remaining_nxt = REM_FULL;
                end
            end
            LOAD: begin
                // abort wins over a handshake in the same cycle: the
                // word is consumed by the sender but never loaded.
                if (abort) begin
                    state_nxt = IDLE;
                end else if (cfg_valid) begin
                    sreg_nxt  = cfg_data;
                    // Final word may be partial; its high bits are never shifted.
                    if (int'(remaining) < WORD_W) begin
                        wcnt_nxt = WW'(remaining);
                    end else begin
                        wcnt_nxt = WCNT_FULL;
                    end
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else begin
                    sreg_nxt      = sreg >> 1;
                    wcnt_nxt      = wcnt - WCNT_ONE;
                    remaining_nxt = remaining - REM_ONE;
                    if (wcnt == WCNT_ONE) begin
                        state_nxt = (remaining == REM_ONE) ? SET : LOAD;
                    end
                end
            end
            SET: begin
                state_nxt = abort ? IDLE : DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // All outputs decode from registered state, so cfg_valid never
    // reaches the chain combinationally.
    assign cfg_ready   = (state == LOAD);
    assign chain_cen   = (state == SHIFT);
    assign chain_shift = (state == SHIFT) & sreg[0];
    assign chain_set   = (state == SET);
    assign busy        = (state != IDLE);
    assign done        = (state == DONE);

endmodule

// File: tb/tb_config_chain_loader.sv
module tb_config_chain_loader;

    logic clk;
    logic rst;

    // Instance A: CHAIN_LEN=10, WORD_W=4
    logic       start_a, abort_a, vld_a, rdy_a, cen_a, shift_a, set_a, busy_a, done_a;
    logic [3:0] dat_a;
    // Instance B: CHAIN_LEN=8, WORD_W=8
    logic       start_b, abort_b, vld_b, rdy_b, cen_b, shift_b, set_b, busy_b, done_b;
    logic [7:0] dat_b;

    config_chain_loader #(.CHAIN_LEN(10), .WORD_W(4)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort_a),
        .cfg_valid(vld_a), .cfg_ready(rdy_a), .cfg_data(dat_a),
        .chain_cen(cen_a), .chain_shift(shift_a), .chain_set(set_a),
        .busy(busy_a), .done(done_a)
    );

    config_chain_loader #(.CHAIN_LEN(8), .WORD_W(8)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort_b),
        .cfg_valid(vld_b), .cfg_ready(rdy_b), .cfg_data(dat_b),
        .chain_cen(cen_b), .chain_shift(shift_b), .chain_set(set_b),
        .busy(busy_b), .done(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboards: expected serial bits, popped by the monitor on each chain_cen cycle.
    bit exp_a[$];
    bit exp_b[$];

    // 0xA, 0x5, 0xF (last word truncated to 2 bits), LSB first.
    localparam bit SEQ_A [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    int cyc = 0;
    int a_cen_cnt = 0, a_set_cnt = 0, a_done_cnt = 0, a_rdy_cnt = 0;
    int a_busy_cyc = 0, a_done_cyc = 0, a_first_cen_cyc = 0;
    bit a_busy_q = 0, a_set_q = 0, a_got_cen = 0;
    int b_cen_cnt = 0, b_set_cnt = 0, b_done_cnt = 0;
    bit b_set_q = 0;

    // Monitor and protocol checker, sampling on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            a_busy_q = 1'b0;
            a_set_q  = 1'b0;
            b_set_q  = 1'b0;
        end else begin
            chk("a_cen_set_excl", int'(cen_a && set_a), 0);
            chk("a_shift_without_cen", int'(shift_a && !cen_a), 0);
            if (done_a) begin
                a_done_cnt++;
                a_done_cyc = cyc;
                chk("a_done_after_set", int'(a_set_q), 1);
            end
            if (busy_a && !a_busy_q) begin
                a_busy_cyc = cyc;
                a_got_cen  = 1'b0;
            end
            if (cen_a) begin
                a_cen_cnt++;
                if (!a_got_cen) begin
                    a_got_cen       = 1'b1;
                    a_first_cen_cyc = cyc;
                end
                chk("a_bit_expected", int'(exp_a.size() > 0), 1);
                if (exp_a.size() > 0) chk("a_bit", int'(shift_a), int'(exp_a.pop_front()));
            end
            if (set_a) a_set_cnt++;
            if (rdy_a) a_rdy_cnt++;
            a_busy_q = busy_a;
            a_set_q  = set_a;

            chk("b_cen_set_excl", int'(cen_b && set_b), 0);
            chk("b_shift_without_cen", int'(shift_b && !cen_b), 0);
            if (done_b) begin
                b_done_cnt++;
                chk("b_done_after_set", int'(b_set_q), 1);
            end
            if (cen_b) begin
                b_cen_cnt++;
                chk("b_bit_expected", int'(exp_b.size() > 0), 1);
                if (exp_b.size() > 0) chk("b_bit", int'(shift_b), int'(exp_b.pop_front()));
            end
            if (set_b) b_set_cnt++;
            b_set_q = set_b;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic a_send(input logic [3:0] d);
        int n = 0;
        dat_a = d;
        vld_a = 1'b1;
        while (!rdy_a && n < 200) begin
            tick();
            n++;
        end
        chk("a_ready_wait", int'(rdy_a), 1);
        tick();
    endtask

    task automatic b_send(input logic [7:0] d);
        int n = 0;
        dat_b = d;
        vld_b = 1'b1;
        while (!rdy_b && n < 200) begin
            tick();
            n++;
        end
        chk("b_ready_wait", int'(rdy_b), 1);
        tick();
    endtask

    // Full 10-bit load on A with optional stall before word 2 and optional
    // start pulse during SHIFT.
    task automatic a_full_load(input int gap, input bit inj_start, input int exp_rdy, input int exp_len);
        int c0, s0, d0, r0, cb, n;
        c0 = a_cen_cnt; s0 = a_set_cnt; d0 = a_done_cnt; r0 = a_rdy_cnt;
        foreach (SEQ_A[i]) exp_a.push_back(SEQ_A[i]);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        a_send(4'hA);
        if (inj_start) begin
            start_a = 1'b1;
            tick();
            start_a = 1'b0;
        end
        if (gap > 0) begin
            vld_a = 1'b0;
            n = 0;
            while (!rdy_a && n < 200) begin
                tick();
                n++;
            end
            cb = a_cen_cnt;
            for (int i = 0; i < gap; i++) begin
                chk("a_stall_ready_high", int'(rdy_a), 1);
                tick();
            end
            chk("a_stall_no_cen", a_cen_cnt - cb, 0);
        end
        a_send(4'h5);
        a_send(4'hF);
        vld_a = 1'b0;
        n = 0;
        while (a_done_cnt == d0 && n < 300) begin
            tick();
            n++;
        end
        chk("a_done_seen", int'(a_done_cnt > d0), 1);
        tick();
        chk("a_idle_after_done", int'(busy_a), 0);
        repeat (3) tick();
        chk("a_stays_idle", int'(busy_a), 0);
        chk("a_cen_count", a_cen_cnt - c0, 10);
        chk("a_set_count", a_set_cnt - s0, 1);
        chk("a_done_count", a_done_cnt - d0, 1);
        chk("a_ready_cycles", a_rdy_cnt - r0, exp_rdy);
        chk("a_load_to_done", a_done_cyc - a_busy_cyc, exp_len);
        chk("a_accept_to_first_bit", a_first_cen_cyc - a_busy_cyc, 1);
        chk("a_queue_drained", exp_a.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, s0, d0;
        rst = 1'b0;
        start_a = 1'b0; abort_a = 1'b0; vld_a = 1'b0; dat_a = '0;
        start_b = 1'b0; abort_b = 1'b0; vld_b = 1'b0; dat_b = '0;
        #2;
        chk("a_reset_outputs", int'({rdy_a, cen_a, shift_a, set_a, busy_a, done_a}), 0);
        chk("b_reset_outputs", int'({rdy_b, cen_b, shift_b, set_b, busy_b, done_b}), 0);
        repeat (2) tick();
        rst = 1'b1;
        repeat (2) tick();
        chk("a_idle_after_reset", int'(busy_a), 0);

        // Basic load, cfg_valid held high.
        a_full_load(0, 1'b0, 3, 14);
        // Five-cycle stall before the second word.
        a_full_load(5, 1'b0, 8, 19);
        // start pulse during SHIFT is ignored.
        a_full_load(0, 1'b1, 3, 14);

        // start and abort together in IDLE; abort colliding with a handshake.
        c0 = a_cen_cnt;
        start_a = 1'b1; abort_a = 1'b1;
        tick();
        start_a = 1'b0; abort_a = 1'b0;
        chk("a_start_abort_idle", int'(busy_a), 0);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("a_in_load", int'(rdy_a), 1);
        dat_a = 4'h3; vld_a = 1'b1; abort_a = 1'b1;
        tick();
        vld_a = 1'b0; abort_a = 1'b0;
        chk("a_abort_handshake_idle", int'(busy_a), 0);
        repeat (3) tick();
        chk("a_abort_handshake_no_cen", a_cen_cnt - c0, 0);

        // Asynchronous reset mid-SHIFT.
        s0 = a_set_cnt; d0 = a_done_cnt;
        foreach (SEQ_A[i]) exp_a.push_back(SEQ_A[i]);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        a_send(4'hA);
        vld_a = 1'b0;
        tick();
        chk("a_mid_shift_before_reset", int'(cen_a), 1);
        #2;
        rst = 1'b0;
        #1;
        chk("a_async_reset_outputs", int'({rdy_a, cen_a, shift_a, set_a, busy_a, done_a}), 0);
        exp_a.delete();
        tick();
        rst = 1'b1;
        repeat (3) tick();
        chk("a_reset_no_set", a_set_cnt - s0, 0);
        chk("a_reset_no_done", a_done_cnt - d0, 0);
        chk("a_idle_after_release", int'(busy_a), 0);
        a_full_load(0, 1'b0, 3, 14);

        // B: abort on the 4th chain_cen cycle. 0xC3 LSB first: 1,1,0,0.
        c0 = b_cen_cnt; s0 = b_set_cnt; d0 = b_done_cnt;
        exp_b.push_back(1'b1); exp_b.push_back(1'b1);
        exp_b.push_back(1'b0); exp_b.push_back(1'b0);
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        b_send(8'hC3);
        vld_b = 1'b0;
        repeat (3) tick();
        abort_b = 1'b1;
        tick();
        abort_b = 1'b0;
        chk("b_abort_busy_low", int'(busy_b), 0);
        repeat (5) tick();
        chk("b_abort_cen_count", b_cen_cnt - c0, 4);
        chk("b_abort_no_set", b_set_cnt - s0, 0);
        chk("b_abort_no_done", b_done_cnt - d0, 0);
        chk("b_queue_drained", exp_b.size(), 0);

        // B: abort on the final bit beats the SHIFT->SET transition.
        // 0x5A LSB first: 0,1,0,1,1,0,1,0.
        c0 = b_cen_cnt; s0 = b_set_cnt; d0 = b_done_cnt;
        exp_b.push_back(1'b0); exp_b.push_back(1'b1);
        exp_b.push_back(1'b0); exp_b.push_back(1'b1);
        exp_b.push_back(1'b1); exp_b.push_back(1'b0);
        exp_b.push_back(1'b1); exp_b.push_back(1'b0);
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        b_send(8'h5A);
        vld_b = 1'b0;
        repeat (7) tick();
        abort_b = 1'b1;
        tick();
        abort_b = 1'b0;
        chk("b_last_abort_busy_low", int'(busy_b), 0);
        repeat (4) tick();
        chk("b_last_abort_cen_count", b_cen_cnt - c0, 8);
        chk("b_last_abort_no_set", b_set_cnt - s0, 0);
        chk("b_last_abort_no_done", b_done_cnt - d0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
